dmem_lsu: RTL and testbench
===========================

DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 SHALL have parameter XLEN, default 32, data and address width in bits.
REQ-002 SHALL have parameter DEPTH, default 1024, memory size in XLEN-bit words; must be a power of two.
REQ-003 SHALL have parameter CLEAR_ON_RESET, default 1, where 1 zero-fills the memory after reset.
REQ-004 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports req_valid  in  1  request present, and req_ready  out  1  request can be accepted.
REQ-007 SHALL have port MemRW  in  1  1=store, 0=load.
REQ-008 SHALL have port funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 SHALL have port ALU_Out  in  XLEN  byte address.
REQ-010 SHALL have port DataW  in  XLEN  store data, right-aligned.
REQ-011 SHALL have ports rsp_valid  out  1  response present, and rsp_ready  in  1  response consumed.
REQ-012 SHALL have port DataR  out  XLEN  load result, registered.
REQ-013 SHALL have port err_code  out  2  00 ok, 01 misaligned, 10 out of range, 11 illegal funct3.

Function
REQ-014 SHALL treat a request as accepted on a rising edge where req_valid and req_ready are both 1.
REQ-015 SHALL implement states CLEAR, IDLE and RESP.
REQ-016 SHALL drive req_ready=1 in IDLE, and in RESP only when rsp_ready=1; req_ready SHALL be 0 in CLEAR.
REQ-017 SHALL use word index ALU_Out[log2(DEPTH)+1:2] and byte offset ALU_Out[1:0].
REQ-018 SHALL flag out of range when any address bit above log2(DEPTH)+1 is nonzero.
REQ-019 SHALL flag misaligned for H/HU when offset[0]=1, and for W when offset is not 00.
REQ-020 SHALL flag illegal funct3 as 11 for stores with 100/101 and for any 011/11x code.
REQ-021 SHALL prioritise errors as illegal > misaligned > out of range.
REQ-022 SHALL, on an accepted error-free store, write only the addressed byte lanes on the accept edge (B: 1 lane, H: 2 lanes, W: 4 lanes), taking data from DataW[7:0], [15:0] or [31:0] respectively; all other bytes SHALL be unchanged.
REQ-023 SHALL, on an accepted error-free load, present the selected byte/half/word in DataR the cycle after accept: sign-extended for B/H, zero-extended for BU/HU/W.
REQ-024 SHALL set DataR=0 for store responses and for any errored request.
REQ-025 SHALL NOT modify memory on an errored request.
REQ-026 SHALL, on any accept, enter RESP with rsp_valid=1 and err_code latched, one cycle after accept.
REQ-027 SHALL hold rsp_valid, DataR and err_code stable in RESP until rsp_ready=1.
REQ-028 SHALL, when rsp_ready=1 in RESP with no new accept, return to IDLE with rsp_valid=0; with a new accept it SHALL stay in RESP and present the new response next cycle (one request per cycle sustained).
REQ-029 SHALL return newly written data to a load accepted one cycle after a store to the same word.

Reset
REQ-030 SHALL, while rst=1 at an edge, set rsp_valid=0, DataR=0, err_code=00, req_ready=0, and the clear counter to 0.
REQ-031 SHALL, after rst deasserts, enter CLEAR if CLEAR_ON_RESET=1 and zero one word per cycle for indices 0..DEPTH-1, then enter IDLE (DEPTH cycles), or enter IDLE directly if CLEAR_ON_RESET=0.
REQ-032 SHALL, on rst asserted mid-CLEAR, restart the clear from index 0; on rst asserted in RESP, discard the pending response.
REQ-033 SHALL initialise all memory words to 0 at simulation time zero.

Verification
REQ-034 SHALL be verified by: reset with DEPTH=16 -> req_ready stays 0 for 16 cycles after rst falls, then 1; loads from words 0..15 return 0.
REQ-035 SHALL be verified by: SW 0x8badf00d @0x10, then LB @0x13 -> 0xffffff8b, LBU @0x13 -> 0x0000008b, LH @0x12 -> 0xffff8bad, LHU @0x10 -> 0x0000f00d.
REQ-036 SHALL be verified by: SB 0x55 @0x11 after the above -> LW @0x10 = 0x8bad550d.
REQ-037 SHALL be verified by: LW @0x12 -> err 01, DataR 0; SH @0x13 -> err 01, memory unchanged; LW @4*DEPTH -> err 10; SB with funct3=100 -> err 11.
REQ-038 SHALL be verified by: rsp_ready held 0 for 3 cycles -> response stable and req_ready=0; then back-to-back loads with rsp_ready=1 -> one response per cycle in order.
REQ-039 SHALL be verified by: rst pulsed at clear index 7 -> clear restarts at 0 and takes a full DEPTH cycles.

Source files
------------

// File: rtl/dmem_lsu.sv
// Byte-addressable data memory load/store unit with a valid/ready request and response handshake.
// Memory can be zero-filled one word per cycle after reset before requests are accepted.
module dmem_lsu #(
  parameter int XLEN           = 32,
  parameter int DEPTH          = 1024,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            MemRW,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] ALU_Out,
  input  logic [XLEN-1:0] DataW,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] DataR,
  output logic [1:0]      err_code
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {CLEAR, IDLE, RESP} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   clr_idx;
  logic [XLEN-1:0] mem [DEPTH] = '{default: '0};

  logic [AW-1:0]   idx;
  logic [1:0]      off;
  logic [4:0]      sh;
  logic            illegal, misal, oor, accept;
  logic [1:0]      err;
  logic [XLEN-1:0] rword, shifted, ld_data, wmask, wdata;

  always_comb begin
    idx     = ALU_Out[AW+1:2];
    off     = ALU_Out[1:0];
    sh      = {off, 3'b000};
    oor     = |ALU_Out[XLEN-1:AW+2];
    // stores have no unsigned variants, so 100/101 are illegal only for them
    illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (MemRW && funct3[2]);
    misal   = ((funct3[1:0] == 2'b01) && off[0]) || ((funct3[1:0] == 2'b10) && (off != 2'b00));
    if (illegal)    err = 2'b11;
    else if (misal) err = 2'b01;
    else if (oor)   err = 2'b10;
    else            err = 2'b00;

    rword   = mem[idx];
    shifted = rword >> sh;
    case (funct3)
      3'b000:  ld_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      3'b001:  ld_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      3'b100:  ld_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
      3'b101:  ld_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: ld_data = shifted;
    endcase

    case (funct3[1:0])
      2'b00:   wmask = XLEN'(8'hff);
      2'b01:   wmask = XLEN'(16'hffff);
      default: wmask = '1;
    endcase
    wmask = wmask << sh;
    wdata = DataW << sh;
  end

  always_comb begin
    req_ready = 1'b0;
    if (!rst) begin
      if (state == IDLE)      req_ready = 1'b1;
      else if (state == RESP) req_ready = rsp_ready;
    end
  end

  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state == RESP);

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR: if (clr_idx == AW'(DEPTH-1)) state_nxt = IDLE;
      IDLE:  if (accept) state_nxt = RESP;
      RESP:  if (rsp_ready && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CLEAR_ON_RESET ? CLEAR : IDLE;
      clr_idx  <= '0;
      DataR    <= '0;
      err_code <= 2'b00;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) clr_idx <= clr_idx + AW'(1);
      if (accept) begin
        err_code <= err;
        DataR    <= (!MemRW && err == 2'b00) ? ld_data : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR)
        mem[clr_idx] <= '0;
      else if (accept && MemRW && err == 2'b00)
        mem[idx] <= (rword & ~wmask) | (wdata & wmask);
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu with DEPTH=16: expected responses are queued on issue
// and compared when the response handshake completes.
module tb_dmem_lsu;
  localparam int DEPTH = 16;
  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

  logic        clk = 1'b0, rst = 1'b1, req_valid = 1'b0, MemRW = 1'b0, rsp_ready = 1'b1;
  logic        req_ready, rsp_valid;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] ALU_Out = '0, DataW = '0, DataR;
  logic [1:0]  err_code;

  int vectors = 0, miscompares = 0;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  err;
    string       name;
  } exp_t;
  exp_t exp_q[$];

  dmem_lsu #(.XLEN(32), .DEPTH(DEPTH), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .MemRW(MemRW),
    .funct3(funct3), .ALU_Out(ALU_Out), .DataW(DataW), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .DataR(DataR), .err_code(err_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid && rsp_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_rsp: got data=%h err=%b, required no response", DataR, err_code);
      end else begin
        e = exp_q.pop_front();
        if (DataR !== e.data || err_code !== e.err) begin
          miscompares++;
          $display("FAIL %s: got data=%h err=%b, required data=%h err=%b",
                   e.name, DataR, err_code, e.data, e.err);
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] ed, input logic [1:0] ee,
                       input string nm, output int waits);
    logic acc;
    exp_t e;
    MemRW = we; funct3 = f3; ALU_Out = addr; DataW = wd; req_valid = 1'b1;
    e.data = ed; e.err = ee; e.name = nm;
    exp_q.push_back(e);
    waits = 0;
    acc = 1'b0;
    while (!acc && waits < 40) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk); #1;
      if (!acc) waits++;
    end
    req_valid = 1'b0;
    if (!acc) begin
      vectors++; miscompares++;
      $display("FAIL %s_accept: got no accept, required accept within 40 cycles", nm);
      void'(exp_q.pop_back());
    end
  endtask

  task automatic req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] ed, input logic [1:0] ee,
                     input string nm);
    int w;
    issue(we, f3, addr, wd, ed, ee, nm, w);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain: got %0d pending, required 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Called right after rst is released; counts cycles with req_ready low.
  task automatic check_clear_time(input string nm);
    int n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    vectors++;
    if (n != DEPTH) begin
      miscompares++;
      $display("FAIL %s: got %0d busy cycles, required %0d", nm, n, DEPTH);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors += 4;
    if (req_ready !== 1'b0) begin miscompares++; $display("FAIL rst_req_ready: got %b, required 0", req_ready); end
    if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_valid: got %b, required 0", rsp_valid); end
    if (DataR !== 32'h0) begin miscompares++; $display("FAIL rst_DataR: got %h, required 0", DataR); end
    if (err_code !== 2'b00) begin miscompares++; $display("FAIL rst_err: got %b, required 00", err_code); end
    rst = 1'b0;
    check_clear_time("clear_time");
    for (int i = 0; i < DEPTH; i++)
      req(1'b0, F_W, 32'(i * 4), 32'h0, 32'h0, 2'b00, $sformatf("clr_lw%0d", i));
    drain("reset");
  endtask

  task automatic test_store_load;
    req(1'b1, F_W,  32'h10, 32'h8badf00d, 32'h0,        2'b00, "sw_10");
    req(1'b0, F_B,  32'h13, 32'h0,        32'hffffff8b, 2'b00, "lb_13");
    req(1'b0, F_BU, 32'h13, 32'h0,        32'h0000008b, 2'b00, "lbu_13");
    req(1'b0, F_H,  32'h12, 32'h0,        32'hffff8bad, 2'b00, "lh_12");
    req(1'b0, F_HU, 32'h10, 32'h0,        32'h0000f00d, 2'b00, "lhu_10");
    req(1'b0, F_W,  32'h10, 32'h0,        32'h8badf00d, 2'b00, "lw_10");
    drain("store_load");
  endtask

  task automatic test_byte_store;
    req(1'b1, F_B, 32'h11, 32'haaaaaa55, 32'h0,        2'b00, "sb_11");
    req(1'b0, F_W, 32'h10, 32'h0,        32'h8bad550d, 2'b00, "lw_after_sb");
    drain("byte_store");
  endtask

  task automatic test_errors;
    req(1'b0, F_W,    32'h12, 32'h0,        32'h0,        2'b01, "lw_misal");
    req(1'b1, F_H,    32'h13, 32'h0000ffff, 32'h0,        2'b01, "sh_misal");
    req(1'b0, F_W,    32'h10, 32'h0,        32'h8bad550d, 2'b00, "lw_after_sh_misal");
    req(1'b0, F_W,    32'h40, 32'h0,        32'h0,        2'b10, "lw_oor");
    req(1'b1, F_BU,   32'h14, 32'h000000ff, 32'h0,        2'b11, "sb_illegal");
    req(1'b0, F_W,    32'h14, 32'h0,        32'h0,        2'b00, "lw_after_illegal");
    req(1'b1, F_W,    32'h50, 32'hdeadbeef, 32'h0,        2'b10, "sw_oor_alias");
    req(1'b0, F_W,    32'h10, 32'h0,        32'h8bad550d, 2'b00, "lw_after_oor");
    req(1'b0, 3'b011, 32'h10, 32'h0,        32'h0,        2'b11, "ld_f3_011");
    req(1'b0, 3'b110, 32'h41, 32'h0,        32'h0,        2'b11, "prio_illegal");
    req(1'b0, F_H,    32'h41, 32'h0,        32'h0,        2'b01, "prio_misal");
    req(1'b0, F_BU,   32'h41, 32'h0,        32'h0,        2'b10, "lbu_oor");
    drain("errors");
  endtask

  task automatic test_stall;
    rsp_ready = 1'b0;
    req(1'b0, F_W, 32'h10, 32'h0, 32'h8bad550d, 2'b00, "stall_lw");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b1 || DataR !== 32'h8bad550d || err_code !== 2'b00 || req_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold%0d: got valid=%b data=%h err=%b ready=%b, required 1 8bad550d 00 0",
                 i, rsp_valid, DataR, err_code, req_ready);
      end
    end
    vectors++;
    if (exp_q.size() != 1) begin
      miscompares++;
      $display("FAIL stall_pending: got %0d, required 1", exp_q.size());
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
  endtask

  task automatic test_back_to_back;
    int w[5];
    issue(1'b1, F_W,  32'h30, 32'h12345678, 32'h0,        2'b00, "b2b_sw_30", w[0]);
    issue(1'b0, F_W,  32'h30, 32'h0,        32'h12345678, 2'b00, "b2b_lw_30", w[1]);
    issue(1'b0, F_B,  32'h13, 32'h0,        32'hffffff8b, 2'b00, "b2b_lb_13", w[2]);
    issue(1'b0, F_HU, 32'h10, 32'h0,        32'h0000550d, 2'b00, "b2b_lhu_10", w[3]);
    issue(1'b0, F_W,  32'h14, 32'h0,        32'h0,        2'b00, "b2b_lw_14", w[4]);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (w[i] != 0) begin
        miscompares++;
        $display("FAIL b2b_wait%0d: got %0d stall cycles, required 0", i, w[i]);
      end
    end
    drain("back_to_back");
  endtask

  task automatic test_clear_restart;
    rsp_ready = 1'b0;
    req(1'b0, F_W, 32'h30, 32'h0, 32'h12345678, 2'b00, "discarded");
    void'(exp_q.pop_back());
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (rsp_valid !== 1'b0 || DataR !== 32'h0 || err_code !== 2'b00) begin
      miscompares++;
      $display("FAIL rst_in_resp: got valid=%b data=%h err=%b, required 0 0 00", rsp_valid, DataR, err_code);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_clear_time("restart_time");
    req(1'b0, F_W, 32'h30, 32'h0, 32'h0, 2'b00, "restart_lw_30");
    req(1'b0, F_W, 32'h10, 32'h0, 32'h0, 2'b00, "restart_lw_10");
    req(1'b0, F_W, 32'h3c, 32'h0, 32'h0, 2'b00, "restart_lw_3c");
    drain("clear_restart");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store_load();
    test_byte_store();
    test_errors();
    test_stall();
    test_back_to_back();
    test_clear_restart();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
